// File: rtl/axi_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_reg_write_arbiter
// Purpose  : Queues and address-checks AXI-lite writes, then round-robins them
//            with core status writes onto one registered register-bank port.
// Revision : 1.0  initial release
// ============================================================================
module axi_reg_write_arbiter #(
  parameter int unsigned         NUM_REGS   = 16,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  localparam int unsigned        IW         = $clog2(NUM_REGS),
  localparam int unsigned        AW         = IW + 3,
  localparam int unsigned        LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          axi_clk,
  input  logic          rstn,
  input  logic          axi_wr_valid,
  input  logic [AW-1:0] axi_wr_addr,
  input  logic [31:0]   axi_wr_data,
  input  logic          core_wr_valid,
  output logic          core_wr_ready,
  input  logic [IW-1:0] core_wr_idx,
  input  logic [31:0]   core_wr_data,
  output logic          reg_wr_en,
  output logic [IW-1:0] reg_wr_idx,
  output logic [31:0]   reg_wr_data,
  output logic          reg_wr_src,
  output logic [LW-1:0] fifo_level,
  output logic          err_overflow,
  output logic          err_addr,
  input  logic          err_clear
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    GNT_AXI  = 1'b0,
    GNT_CORE = 1'b1
  } grant_e;

  logic [IW-1:0] fifo_idx_q  [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  grant_e        last_q, last_d;
  logic          en_q, en_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   data_q, data_d;
  logic          src_q, src_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_addr_q, err_addr_d;

  logic [IW-1:0] axi_idx;
  logic          addr_bad;
  logic          push_req;
  logic          fifo_full;
  logic          fne;
  logic          grant_core;
  logic          grant_axi;
  logic          push;
  logic          pop;

  // Misaligned, beyond the register window (top address bit) or read-only.
  assign axi_idx   = axi_wr_addr[IW+1:2];
  assign addr_bad  = (axi_wr_addr[1:0] != 2'b00) | axi_wr_addr[AW-1] | RO_MASK[axi_idx];
  assign push_req  = axi_wr_valid & ~addr_bad;
  assign fifo_full = (level_q == LW'(FIFO_DEPTH));
  assign fne       = (level_q != '0);

  // Core is only held off when the FIFO is waiting and the core won last time.
  assign core_wr_ready = rstn & (~fne | (last_q == GNT_AXI));
  assign grant_core    = core_wr_valid & core_wr_ready;
  assign grant_axi     = fne & ~grant_core;

  // A same-cycle pop frees the slot a full-FIFO push needs.
  assign pop  = grant_axi;
  assign push = push_req & (~fifo_full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_d     = last_q;
    en_d       = 1'b0;
    idx_d      = idx_q;
    data_d     = data_q;
    src_d      = src_q;
    err_ovf_d  = (push_req & fifo_full & ~pop) | (err_ovf_q & ~err_clear);
    err_addr_d = (axi_wr_valid & addr_bad) | (err_addr_q & ~err_clear);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (grant_core) begin
      en_d   = 1'b1;
      idx_d  = core_wr_idx;
      data_d = core_wr_data;
      src_d  = 1'b1;
      last_d = GNT_CORE;
    end else if (grant_axi) begin
      en_d   = 1'b1;
      idx_d  = fifo_idx_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
      src_d  = 1'b0;
      last_d = GNT_AXI;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_q     <= GNT_CORE;
      en_q       <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      src_q      <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_q     <= last_d;
      en_q       <= en_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      src_q      <= src_d;
      err_ovf_q  <= err_ovf_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge axi_clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= axi_idx;
      fifo_data_q[wr_ptr_q] <= axi_wr_data;
    end
  end

  assign reg_wr_en    = en_q;
  assign reg_wr_idx   = idx_q;
  assign reg_wr_data  = data_q;
  assign reg_wr_src   = src_q;
  assign fifo_level   = level_q;
  assign err_overflow = err_ovf_q;
  assign err_addr     = err_addr_q;

endmodule
`default_nettype wire
